// File: rtl/div_ctrl_pkg.sv
// Shared types for the iterative divide controller: op codes, FSM states
// and the 64-bit word type used across the divide datapath.
package div_ctrl_pkg;

  typedef logic [63:0] u64;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

  localparam u64 INT64_MIN    = 64'h8000_0000_0000_0000;
  localparam u64 INT32_MIN_SX = 64'hFFFF_FFFF_8000_0000;

  function automatic u64 sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Valid/data_ok link between the divide controller and the unsigned
// iterative divider.
interface div_ctrl_if;
  import div_ctrl_pkg::*;

  logic div_valid;
  u64   div_srca;
  u64   div_srcb;
  u64   div_quot;
  u64   div_rem;
  logic div_data_ok;

  modport master (
    output div_valid, div_srca, div_srcb,
    input  div_quot, div_rem, div_data_ok
  );

  modport slave (
    input  div_valid, div_srca, div_srcb,
    output div_quot, div_rem, div_data_ok
  );

endinterface

// File: rtl/div_ctrl_fixup.sv
// Combinational sign handling for RV64M divide/remainder: effective-width
// operands, sign flags, magnitudes, special-case detection and the final
// negate plus W-form sign extension.
module div_fixup
  import div_ctrl_pkg::*;
(
  input  div_op_t op,
  input  logic    word,
  input  u64      a,
  input  u64      b,
  input  logic    use_div,
  input  u64      quot,
  input  u64      rem,
  input  logic    neg_quot,
  input  logic    neg_rem,
  output u64      mag_a,
  output u64      mag_b,
  output logic    sign_a,
  output logic    sign_b,
  output logic    special,
  output u64      result
);

  logic is_signed;
  logic is_rem;
  logic b_zero;
  logic ovf;
  logic neg;
  u64   a_eff;
  u64   b_eff;
  u64   raw;
  u64   fixed;

  // Operand conditioning and result fix-up for the current op.
  always_comb begin
    is_signed = ~op[0];
    is_rem    = op[1];

    if (word) begin
      a_eff = is_signed ? sext32(a[31:0]) : {32'h0, a[31:0]};
      b_eff = is_signed ? sext32(b[31:0]) : {32'h0, b[31:0]};
    end else begin
      a_eff = a;
      b_eff = b;
    end

    sign_a = is_signed & a_eff[63];
    sign_b = is_signed & b_eff[63];
    // |INT_MIN| wraps to itself, which is the right unsigned magnitude.
    mag_a  = sign_a ? -a_eff : a_eff;
    mag_b  = sign_b ? -b_eff : b_eff;

    b_zero  = (b_eff == '0);
    ovf     = is_signed && (a_eff == (word ? INT32_MIN_SX : INT64_MIN)) && (b_eff == '1);
    special = b_zero | ovf;

    if (use_div) begin
      raw = is_rem ? rem : quot;
    end else if (b_zero) begin
      raw = is_rem ? a_eff : '1;
    end else begin
      raw = is_rem ? '0 : a_eff;
    end

    neg    = use_div & (is_rem ? neg_rem : neg_quot);
    fixed  = neg ? -raw : raw;
    result = word ? sext32(fixed[31:0]) : fixed;
  end

endmodule

// File: rtl/div_ctrl.sv
// Execute-stage divide controller: accepts RV64M DIV/REM ops, drives the
// unsigned iterative divider, resolves divide-by-zero and signed overflow
// locally, and holds the result until the consumer takes it.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned MAX_WAIT = 80
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            err,
  div_ctrl_if.master      div_bus
);

  localparam int unsigned WD_W = $clog2(MAX_WAIT + 1);

  div_state_t      state_q;
  div_state_t      state_d;
  div_op_t         op_q;
  logic            word_q;
  logic            neg_quot_q;
  logic            neg_rem_q;
  u64              srca_q;
  u64              srcb_q;
  u64              result_q;
  logic            err_q;
  logic [WD_W-1:0] wd_cnt_q;

  logic    in_busy;
  logic    wd_expired;
  div_op_t fx_op;
  logic    fx_word;
  u64      fx_mag_a;
  u64      fx_mag_b;
  logic    fx_sign_a;
  logic    fx_sign_b;
  logic    fx_special;
  u64      fx_result;

  assign in_busy    = (state_q == BUSY);
  assign wd_expired = (wd_cnt_q == WD_W'(MAX_WAIT - 1));

  // One fix-up instance serves both ends: outside BUSY it sees the incoming
  // request (operand prep, special results); in BUSY it sees the latched op
  // and the divider outputs (result fix-up).
  assign fx_op   = in_busy ? op_q : div_op_t'(req_op);
  assign fx_word = in_busy ? word_q : req_word;

  div_fixup u_fixup (
    .op       (fx_op),
    .word     (fx_word),
    .a        (req_a),
    .b        (req_b),
    .use_div  (in_busy),
    .quot     (div_bus.div_quot),
    .rem      (div_bus.div_rem),
    .neg_quot (neg_quot_q),
    .neg_rem  (neg_rem_q),
    .mag_a    (fx_mag_a),
    .mag_b    (fx_mag_b),
    .sign_a   (fx_sign_a),
    .sign_b   (fx_sign_b),
    .special  (fx_special),
    .result   (fx_result)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (req_valid) state_d = fx_special ? DONE : BUSY;
        BUSY:    if (div_bus.div_data_ok || wd_expired) state_d = DONE;
        DONE:    if (resp_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from the registered state and datapath registers.
  always_comb begin
    req_ready        = (state_q == IDLE);
    resp_valid       = (state_q == DONE);
    div_bus.div_valid = (state_q == BUSY);
    div_bus.div_srca = srca_q;
    div_bus.div_srcb = srcb_q;
    resp_data        = result_q;
    err              = err_q;
  end

  // Operand/flag capture on accept, result capture, watchdog and sticky err.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q       <= DIV;
      word_q     <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      srca_q     <= '0;
      srcb_q     <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      wd_cnt_q   <= '0;
    end else if (flush) begin
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q       <= div_op_t'(req_op);
            word_q     <= req_word;
            neg_quot_q <= fx_sign_a ^ fx_sign_b;
            neg_rem_q  <= fx_sign_a;
            wd_cnt_q   <= '0;
            if (fx_special) begin
              result_q <= fx_result;
            end else begin
              srca_q <= fx_mag_a;
              srcb_q <= fx_mag_b;
            end
          end
        end
        BUSY: begin
          if (div_bus.div_data_ok) begin
            result_q <= fx_result;
          end else if (wd_expired) begin
            result_q <= '0;
            err_q    <= 1'b1;
          end else begin
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: a behavioural divider answers the
// valid/data_ok link, and results are compared with an arithmetic model of
// the RV64M divide/remainder rules.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_op = 2'd0;
  logic       req_word = 1'b0;
  u64         req_a = '0;
  u64         req_b = '0;
  logic       flush = 1'b0;
  logic       resp_ready = 1'b0;
  logic       req_ready;
  logic       resp_valid;
  u64         resp_data;
  logic       err;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        stall = 1'b0;
  logic        noise = 1'b0;
  int unsigned vcnt = 0;

  div_ctrl_if dif ();

  div_ctrl #(.XLEN(64), .MAX_WAIT(80)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_word   (req_word),
    .req_a      (req_a),
    .req_b      (req_b),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .err        (err),
    .div_bus    (dif)
  );

  always #5 clk = ~clk;

  // Divider: answers with data_ok in the cycle after the 65th valid-high edge;
  // optionally stalls forever, or pulses data_ok with junk while not busy.
  initial begin
    dif.div_data_ok = 1'b0;
    dif.div_quot    = '0;
    dif.div_rem     = '0;
    forever begin
      @(negedge clk);
      if (dif.div_valid === 1'b1) begin
        vcnt++;
        if (vcnt == 66 && !stall) begin
          dif.div_data_ok = 1'b1;
          dif.div_quot    = dif.div_srca / dif.div_srcb;
          dif.div_rem     = dif.div_srca % dif.div_srcb;
        end else begin
          dif.div_data_ok = 1'b0;
          dif.div_quot    = {$urandom, $urandom};
          dif.div_rem     = {$urandom, $urandom};
        end
      end else begin
        vcnt            = 0;
        dif.div_data_ok = noise && ($urandom_range(0, 3) == 0);
        dif.div_quot    = {$urandom, $urandom};
        dif.div_rem     = {$urandom, $urandom};
      end
    end
  end

  task automatic check(input string tag, input u64 got, input u64 exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic u64 ref_result(input logic [1:0] op, input logic w, input u64 a, input u64 b);
    logic   is_rem, sgn;
    int     x, y, r32;
    longint lx, ly, r64;
    is_rem = op[1];
    sgn    = ~op[0];
    if (w) begin
      x = int'(a[31:0]);
      y = int'(b[31:0]);
      if (y == 0)                                        r32 = is_rem ? x : -1;
      else if (sgn && x == int'(32'h8000_0000) && y == -1) r32 = is_rem ? 0 : x;
      else if (sgn)                                      r32 = is_rem ? x % y : x / y;
      else r32 = is_rem ? int'(a[31:0] % b[31:0]) : int'(a[31:0] / b[31:0]);
      return u64'(longint'(r32));
    end
    lx = longint'(a);
    ly = longint'(b);
    if (ly == 0)                          r64 = is_rem ? lx : -1;
    else if (sgn && a == INT64_MIN && ly == -1) r64 = is_rem ? 0 : lx;
    else if (sgn)                         r64 = is_rem ? lx % ly : lx / ly;
    else                                  r64 = is_rem ? longint'(a % b) : longint'(a / b);
    return u64'(r64);
  endfunction

  function automatic logic ref_special(input logic [1:0] op, input logic w, input u64 a, input u64 b);
    logic sgn;
    sgn = ~op[0];
    if (w) return (b[31:0] == 32'h0) ||
                  (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == '0) || (sgn && a == INT64_MIN && b == '1);
  endfunction

  // Presents one request at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic [1:0] op, input logic w, input u64 a, input u64 b);
    req_op    = op;
    req_word  = w;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    check("req_ready_idle", u64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = {$urandom, $urandom};
    req_b     = {$urandom, $urandom};
  endtask

  task automatic do_op(input logic [1:0] op, input logic w, input u64 a, input u64 b,
                       input u64 exp, input int hold);
    logic spec;
    u64   sa, sb;
    int   n, viol;
    spec = ref_special(op, w, a, b);
    issue(op, w, a, b);
    sa   = dif.div_srca;
    sb   = dif.div_srcb;
    n    = 1;
    viol = 0;
    while (resp_valid !== 1'b1 && n < 200) begin
      if (req_ready !== 1'b0) viol++;
      if (dif.div_valid !== !spec) viol++;
      if (!spec && (dif.div_srca !== sa || dif.div_srcb !== sb)) viol++;
      @(negedge clk);
      n++;
    end
    // Edges after acceptance before resp_valid is seen: 66 via the divider,
    // 0 for a special case (result already visible in the next cycle).
    check("latency", u64'(n - 1), spec ? 64'd0 : 64'd66);
    check("busy_protocol", u64'(viol), 64'd0);
    check("div_valid_dropped", u64'(dif.div_valid), 64'd0);
    check("resp_data", resp_data, exp);
    if (hold > 0) begin
      viol = 0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_data !== exp) viol++;
      end
      check("done_hold", u64'(viol), 64'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("back_to_idle", u64'(req_ready), 64'd1);
    check("idle_div_valid", u64'(dif.div_valid), 64'd0);
  endtask

  typedef struct {
    logic [1:0] op;
    logic       w;
    u64         a;
    u64         b;
    u64         exp;
    int         hold;
  } vec_t;

  vec_t dir [10] = '{
    '{2'd1, 1'b0, 64'd100,                 64'd7,                 64'd14,                 0},
    '{2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,                 64'hFFFF_FFFF_FFFF_FFF2, 2},
    '{2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,                 64'hFFFF_FFFF_FFFF_FFFE, 0},
    '{2'd2, 1'b0, 64'd100,                 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                  1},
    '{2'd1, 1'b0, 64'd5,                   64'd0,                 64'hFFFF_FFFF_FFFF_FFFF, 0},
    '{2'd3, 1'b0, 64'd5,                   64'd0,                 64'd5,                  0},
    '{2'd0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0},
    '{2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                  0},
    '{2'd0, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0},
    '{2'd1, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1,                 64'hFFFF_FFFF_FFFF_FFFF, 10}
  };

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] op;
    logic       w;
    u64         a, b;
    int         n;
    logic       prev_err;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_req_ready", u64'(req_ready), 64'd1);
    check("rst_resp_valid", u64'(resp_valid), 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_err", u64'(err), 64'd0);
    check("rst_div_valid", u64'(dif.div_valid), 64'd0);
    check("rst_srca", dif.div_srca, 64'd0);
    check("rst_srcb", dif.div_srcb, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Directed cases.
    foreach (dir[i]) do_op(dir[i].op, dir[i].w, dir[i].a, dir[i].b, dir[i].exp, dir[i].hold);

    // Randomised ops, with divide-by-zero and overflow patterns mixed in.
    noise = 1'b1;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = w ? {b[63:32], 32'h0} : 64'd0;
        1: begin
          a = w ? {a[63:32], 32'h8000_0000} : INT64_MIN;
          b = w ? {b[63:32], 32'hFFFF_FFFF} : '1;
        end
        2: begin
          a = u64'($urandom_range(0, 1000));
          b = u64'($urandom_range(1, 50));
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: ;
      endcase
      do_op(op, w, a, b, ref_result(op, w, a, b), int'($urandom_range(0, 3)));
    end
    noise = 1'b0;

    // Flush in BUSY cycle 30, with a request presented alongside it.
    issue(2'd1, 1'b0, 64'd1000, 64'd7);
    repeat (29) @(negedge clk);
    check("busy_before_flush", u64'(dif.div_valid), 64'd1);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = 2'd1;
    req_a     = 64'd9;
    req_b     = 64'd3;
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    check("flush_div_valid", u64'(dif.div_valid), 64'd0);
    check("flush_resp_valid", u64'(resp_valid), 64'd0);
    check("flush_idle", u64'(req_ready), 64'd1);
    do_op(2'd1, 1'b0, 64'd9, 64'd3, 64'd3, 0);

    // Flush in DONE discards the pending result.
    issue(2'd1, 1'b0, 64'd5, 64'd0);
    check("special_done", u64'(resp_valid), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_done_resp_valid", u64'(resp_valid), 64'd0);
    check("flush_done_idle", u64'(req_ready), 64'd1);

    // Watchdog: divider never answers.
    stall = 1'b1;
    issue(2'd1, 1'b0, 64'd100, 64'd7);
    n        = 1;
    prev_err = err;
    while (resp_valid !== 1'b1 && n < 200) begin
      prev_err = err;
      @(negedge clk);
      n++;
    end
    check("wd_latency", u64'(n - 1), 64'd80);
    check("wd_err_before", u64'(prev_err), 64'd0);
    check("wd_err", u64'(err), 64'd1);
    check("wd_resp_data", resp_data, 64'd0);
    check("wd_div_valid", u64'(dif.div_valid), 64'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    stall      = 1'b0;
    do_op(2'd3, 1'b0, 64'd10, 64'd4, 64'd2, 0);
    check("err_sticky", u64'(err), 64'd1);

    // Asynchronous reset in the middle of BUSY.
    issue(2'd0, 1'b0, 64'd1000, 64'd7);
    repeat (20) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async_div_valid", u64'(dif.div_valid), 64'd0);
    check("async_resp_valid", u64'(resp_valid), 64'd0);
    check("async_resp_data", resp_data, 64'd0);
    check("async_err", u64'(err), 64'd0);
    check("async_srca", dif.div_srca, 64'd0);
    check("async_req_ready", u64'(req_ready), 64'd1);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    do_op(2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
